// File: rtl/acc_bias_unit.sv
// acc_bias_unit: per-column partial-sum accumulator with bias add, feeding the int8 saturation stage.
module acc_bias_unit #(
    parameter int COLS    = 5,
    parameter int PS_BW   = 16,
    parameter int BIAS_BW = 16,
    parameter int AB_BW   = 25,
    parameter int CNT_BW  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [CNT_BW-1:0]       i_num_pass,
    input  logic [BIAS_BW*COLS-1:0] i_bias,
    input  logic                    i_ps_valid,
    input  logic [PS_BW*COLS-1:0]   i_psum,
    output logic [AB_BW*COLS-1:0]   o_acc_bias,
    output logic                    o_valid,
    output logic                    o_busy
);
    typedef enum logic [1:0] {IDLE, ACC, BIAS, OUT} state_t;
    state_t                  state_q, state_d;
    logic [CNT_BW-1:0]       cnt_q, cnt_d;
    logic [BIAS_BW*COLS-1:0] bias_q, bias_d;
    logic [AB_BW-1:0]        acc_q [COLS];
    logic [AB_BW-1:0]        acc_d [COLS];
    logic [AB_BW*COLS-1:0]   out_q, out_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        acc_d   = acc_q;
        out_d   = out_q;
        case (state_q)
            IDLE: if (i_start) begin
                bias_d  = i_bias;
                cnt_d   = i_num_pass;
                for (int c = 0; c < COLS; c++) acc_d[c] = '0;
                state_d = (i_num_pass != '0) ? ACC : BIAS;
            end
            ACC: if (i_ps_valid) begin
                for (int c = 0; c < COLS; c++)
                    acc_d[c] = acc_q[c] + {{(AB_BW-PS_BW){i_psum[c*PS_BW+PS_BW-1]}}, i_psum[c*PS_BW +: PS_BW]};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CNT_BW'(1)) ? BIAS : ACC;
            end
            // Result register is loaded here so it is already valid during the OUT strobe.
            BIAS: begin
                for (int c = 0; c < COLS; c++) begin
                    acc_d[c] = acc_q[c] + {{(AB_BW-BIAS_BW){bias_q[c*BIAS_BW+BIAS_BW-1]}}, bias_q[c*BIAS_BW +: BIAS_BW]};
                    out_d[c*AB_BW +: AB_BW] = acc_d[c];
                end
                state_d = OUT;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bias_q  <= '0;
            out_q   <= '0;
            for (int c = 0; c < COLS; c++) acc_q[c] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
            out_q   <= out_d;
            acc_q   <= acc_d;
        end
    end
    assign o_acc_bias = out_q;
    assign o_valid    = (state_q == OUT);
    assign o_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_acc_bias_unit.sv
// tb_acc_bias_unit: directed vector table plus hand sequences for acc_bias_unit.
module tb_acc_bias_unit;
    localparam int COLS = 5;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [7:0]    i_num_pass = '0;
    logic [79:0]   i_bias = '0;
    logic          i_ps_valid = 1'b0;
    logic [79:0]   i_psum = '0;
    logic [124:0]  o_acc_bias;
    logic          o_valid, o_busy;
    logic [99:0]   o_acc20;
    logic          o_valid20, o_busy20;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    acc_bias_unit dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_pass(i_num_pass),
        .i_bias(i_bias), .i_ps_valid(i_ps_valid), .i_psum(i_psum),
        .o_acc_bias(o_acc_bias), .o_valid(o_valid), .o_busy(o_busy)
    );

    acc_bias_unit #(.AB_BW(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_pass(i_num_pass),
        .i_bias(i_bias), .i_ps_valid(i_ps_valid), .i_psum(i_psum),
        .o_acc_bias(o_acc20), .o_valid(o_valid20), .o_busy(o_busy20)
    );

    typedef struct {
        string name;
        int    n;
        int    ps;
        bit    scale;
        int    bias;
        int    gap;
        int    exp;
        int    step;
        int    exp20;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int col(input int c);
        logic [24:0] v;
        v = o_acc_bias[c*25 +: 25];
        return int'($signed(v));
    endfunction

    function automatic int col20(input int c);
        logic [19:0] v;
        v = o_acc20[c*20 +: 20];
        return int'($signed(v));
    endfunction

    task automatic start_tile(input int n, input int b);
        i_start = 1'b1;
        i_num_pass = 8'(n);
        for (int c = 0; c < COLS; c++) i_bias[c*16 +: 16] = 16'(b);
        tick();
        i_start = 1'b0;
    endtask

    task automatic beat(input int ps, input bit scale);
        i_ps_valid = 1'b1;
        for (int c = 0; c < COLS; c++) i_psum[c*16 +: 16] = 16'(scale ? ps * (c + 1) : ps);
        tick();
        i_ps_valid = 1'b0;
    endtask

    // Called right after the last beat edge (or the start edge when N=0): BIAS now, OUT next.
    task automatic finish_tile(input string tag, input int exp, input int step, input int exp20);
        chk({tag, " valid_in_bias"}, int'(o_valid), 0);
        tick();
        chk({tag, " valid_strobe"}, int'(o_valid), 1);
        for (int c = 0; c < COLS; c++) chk($sformatf("%s col%0d", tag, c), col(c), exp + c * step);
        chk({tag, " col0_ab20"}, col20(0), exp20);
        tick();
        chk({tag, " valid_drop"}, int'(o_valid), 0);
        chk({tag, " busy_drop"}, int'(o_busy), 0);
        chk({tag, " hold"}, col(0), exp);
    endtask

    task automatic run_tile(input vec_t v);
        start_tile(v.n, v.bias);
        chk({v.name, " busy"}, int'(o_busy), 1);
        for (int i = 0; i < v.n; i++) begin
            beat(v.ps, v.scale);
            if (i < v.n - 1)
                for (int g = 0; g < v.gap; g++) begin
                    tick();
                    chk({v.name, " valid_in_gap"}, int'(o_valid), 0);
                end
        end
        finish_tile(v.name, v.exp, v.step, v.exp20);
    endtask

    initial begin
        tbl[0] = '{"bubbles",   4, -32768, 1'b0, -32768, 1, -163840,    0, -163840};
        tbl[1] = '{"wrap_pos",  255, 32767, 1'b0, 32767, 0, 8388352,    0, -256};
        tbl[2] = '{"wrap_neg",  255, -32768, 1'b0, -32768, 0, -8388608, 0, 0};
        tbl[3] = '{"n_zero",    0, 0, 1'b0, 5, 0, 5,                    0, 5};
        tbl[4] = '{"scaled2",   2, 1000, 1'b1, -7, 0, 1993,          2000, 1993};
        tbl[5] = '{"scaled1",   1, -3, 1'b1, 0, 2, -3,                 -3, -3};

        i_psum = 80'hDEAD_BEEF_1234_5678_9ABC;
        i_ps_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset acc", int'(o_acc_bias == '0), 1);
        chk("reset valid", int'(o_valid), 0);
        chk("reset busy", int'(o_busy), 0);
        i_ps_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("idle busy", int'(o_busy), 0);

        // Basic N=3 tile with a start pulse mid-ACC that must be ignored.
        start_tile(3, 10);
        beat(100, 1'b1);
        i_start = 1'b1;
        i_num_pass = 8'd1;
        beat(-50, 1'b1);
        i_start = 1'b0;
        chk("basic busy", int'(o_busy), 1);
        beat(7, 1'b1);
        finish_tile("basic", 67, 57, 67);

        for (int i = 0; i < 6; i++) run_tile(tbl[i]);

        // Reset after 2 of 4 beats discards the tile and clears the output.
        start_tile(4, 9);
        beat(50, 1'b0);
        beat(50, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset acc", int'(o_acc_bias == '0), 1);
        chk("midreset valid", int'(o_valid), 0);
        chk("midreset busy", int'(o_busy), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        start_tile(1, 4);
        beat(3, 1'b1);
        finish_tile("after_reset", 7, 3, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
